// File: rtl/axi_mul_slave_if.sv
// Request/response bundle between a master and the multiplier slave.
// M carries operands plus a request strobe; S carries the product halves and a done pulse.
interface axi #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 32
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [ADDR_WIDTH-1:0] b;
        logic                  c;
    } m_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] e;
        logic                  f;
    } s_t;

    m_t M;
    s_t S;

    modport Master (output M, input S);
    modport Slave  (input M, output S);
endinterface

// File: rtl/axi_mul_slave.sv
// Queued serial shift-add multiplier behind the axi Slave modport.
// Requests without room in the FIFO are dropped and counted.
module axi_mul_slave #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    axi.Slave          bus,
    output logic       overflow,
    output logic [7:0] drop_cnt,
    output logic       busy
);
    localparam int W  = 2 * DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    generate
        if (W > ADDR_WIDTH) begin : g_width_chk
            $error("axi_mul_slave: 2*DATA_WIDTH must not exceed ADDR_WIDTH");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
            $error("axi_mul_slave: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    mem_a [FIFO_DEPTH];
    logic [W-1:0]    mem_b [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [W-1:0]    op_a, op_b, acc, acc_nxt;
    logic [CW-1:0]   cnt;
    logic [DATA_WIDTH-1:0] d_q, e_q;
    logic            pop, push, drop, last;

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign pop  = (state == IDLE || state == DONE) && count != '0;
    assign push = bus.M.c && (count != FULL || pop);
    assign drop = bus.M.c && !push;
    assign last = cnt == CW'(W - 1);
    assign busy = state != IDLE || count != '0;

    assign acc_nxt = op_b[cnt] ? acc + (op_a << cnt) : acc;

    assign bus.S = {d_q, e_q, state == DONE};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.M.a[W-1:0];
            mem_b[wr_ptr] <= bus.M.b[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            cnt   <= '0;
            d_q   <= '0;
            e_q   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                op_a <= mem_a[rd_ptr];
                op_b <= mem_b[rd_ptr];
                acc  <= '0;
                cnt  <= '0;
            end else if (state == CALC) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
            if (state == CALC && last) begin
                d_q <= acc_nxt[DATA_WIDTH-1:0];
                e_q <= acc_nxt[W-1:DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pop) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = pop ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_mul_slave.sv
// Scoreboard bench for axi_mul_slave: expected products queued at issue,
// compared against pulses captured by a negedge monitor.
module tb_axi_mul_slave;
    localparam int DW = 4;
    localparam int AW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       busy;

    axi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    axi_mul_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_p[$];
    int         obs_c[$];

    always @(negedge clk) begin
        if (rst_n && bus_if.S.f) begin
            obs_p.push_back({bus_if.S.e, bus_if.S.d});
            obs_c.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit keep);
        logic [15:0] full;
        full = a[7:0] * b[7:0];
        bus_if.M.a = a;
        bus_if.M.b = b;
        bus_if.M.c = 1'b1;
        if (keep) exp_q.push_back(full[7:0]);
        @(posedge clk);
        #1;
        bus_if.M.c = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_p.delete();
        obs_c.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.M.a = '0;
        bus_if.M.b = '0;
        bus_if.M.c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.S.f, bus_if.S.d, bus_if.S.e} !== 9'h0) begin
            errors++;
            $display("FAIL reset_s got f/d/e=%b/%h/%h want 0/0/0",
                     bus_if.S.f, bus_if.S.d, bus_if.S.e);
        end
        checks++;
        if ({overflow, drop_cnt, busy} !== 10'h0) begin
            errors++;
            $display("FAIL reset_status got ovf=%b drop=%0d busy=%b want 0/0/0",
                     overflow, drop_cnt, busy);
        end
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_single();
        int t0;
        repeat (2) @(negedge clk);
        send(32'h13, 32'h0B, 1);
        t0 = cyc;
        for (int k = 0; k < 20 && obs_p.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_p.size() < 1) begin
            errors++;
            $display("FAIL single_timeout got 0 pulses want 1");
        end else begin
            checks++;
            if (obs_p[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL single_prod got %h want %h", obs_p[0], exp_q[0]);
            end
            checks++;
            if (obs_c[0] - t0 !== 9) begin
                errors++;
                $display("FAIL single_latency got %0d want 9", obs_c[0] - t0);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.S.e, bus_if.S.d, bus_if.S.f, busy} !== {8'hD1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_hold got e/d=%h/%h f=%b busy=%b want D/1 0 0",
                     bus_if.S.e, bus_if.S.d, bus_if.S.f, busy);
        end
        clear_q();
    endtask

    task automatic test_operand(input logic [31:0] a, input logic [31:0] b, input string nm);
        repeat (2) @(negedge clk);
        send(a, b, 1);
        for (int k = 0; k < 20 && obs_p.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_p.size() < 1) begin
            errors++;
            $display("FAIL %s_timeout got 0 pulses want 1", nm);
        end else begin
            checks++;
            if (obs_p[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL %s_prod got %h want %h", nm, obs_p[0], exp_q[0]);
            end
        end
        clear_q();
    endtask

    task automatic test_overflow();
        int t0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            send(32'(i), 32'(i + 1), i <= 5);
            if (i == 1) t0 = cyc;
        end
        for (int k = 0; k < 80 && obs_p.size() < 5; k++) @(negedge clk);
        repeat (12) @(negedge clk);
        checks++;
        if (obs_p.size() != 5) begin
            errors++;
            $display("FAIL ovf_count got %0d pulses want 5", obs_p.size());
        end
        for (int i = 0; i < 5 && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_prod[%0d] got %h want %h", i, obs_p[i], exp_q[i]);
            end
            checks++;
            if (obs_c[i] - (i == 0 ? t0 : obs_c[i-1]) !== 9) begin
                errors++;
                $display("FAIL ovf_gap[%0d] got %0d want 9", i,
                         obs_c[i] - (i == 0 ? t0 : obs_c[i-1]));
            end
        end
        checks++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ovf_flags got ovf=%b drop=%0d want 1/1", overflow, drop_cnt);
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) send(32'(i + 2), 32'(i + 3), 1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.S.f, bus_if.S.d, bus_if.S.e, overflow, drop_cnt, busy} !== 19'h0) begin
            errors++;
            $display("FAIL mid_reset got f=%b d=%h e=%h ovf=%b drop=%0d busy=%b want all 0",
                     bus_if.S.f, bus_if.S.d, bus_if.S.e, overflow, drop_cnt, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        repeat (30) @(negedge clk);
        checks++;
        if (obs_p.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet got pulses=%0d busy=%b want 0/0", obs_p.size(), busy);
        end
        send(32'h7, 32'h3, 1);
        for (int k = 0; k < 20 && obs_p.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_p.size() < 1 || obs_p[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL mid_after got %0d pulses want 1 with %h", obs_p.size(), exp_q[0]);
        end
        clear_q();
    endtask

    task automatic test_saturation();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) send(32'(i), 32'h3, 0);
        checks++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd255}) begin
            errors++;
            $display("FAIL sat_flags got ovf=%b drop=%0d want 1/255", overflow, drop_cnt);
        end
        repeat (60) @(negedge clk);
        checks++;
        if ({overflow, drop_cnt, busy} !== {1'b1, 8'd255, 1'b0}) begin
            errors++;
            $display("FAIL sat_hold got ovf=%b drop=%0d busy=%b want 1/255/0",
                     overflow, drop_cnt, busy);
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_single();
        test_operand(32'hFFFF_FFFF, 32'h0000_00FF, "wrap");
        test_operand(32'h5, 32'h0, "zero");
        test_operand(32'hABCD_0037, 32'h1234_0029, "mask");
        test_overflow();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mul_slave.md
# axi_mul_slave

Slave-side consumer of the `axi` interface, connected to its `Slave` modport: it captures requests the master drives on `M`, queues them, and runs each through a serial shift-add multiplier. It returns each product on `S` as a one-cycle `f` pulse. The interface has no back-pressure, so the block buffers bursts in a small FIFO and flags any request it has to drop.

## Interface
- `DATA_WIDTH`, 4: width of `S.d` and `S.e`; must match the connected interface instance.
- `ADDR_WIDTH`, 32: width of `M.a` and `M.b`; must match the interface; `2*DATA_WIDTH <= ADDR_WIDTH` is required (elaboration error otherwise).
- `FIFO_DEPTH`, 4: request queue entries, power of two, at least 2.

- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `bus`  modport  axi.Slave  reads `M.a`, `M.b`, `M.c`; drives `S.d`, `S.e`, `S.f`.
- `overflow`  output  1  sticky; set when a request is dropped.
- `drop_cnt`  output  8  count of dropped requests, saturates at 255.
- `busy`  output  1  high when the engine is not IDLE or the FIFO is non-empty.

## Operation
- **Request:** `M.c`=1 at a rising edge is one request. Its operands are `A = M.a[2*DW-1:0]` and `B = M.b[2*DW-1:0]`, where DW = DATA_WIDTH. Upper bits are ignored.
- **Result:** `P = (A*B) mod 2^(2*DW)`. Output `S.d = P[DW-1:0]` and `S.e = P[2*DW-1:DW]`.
- **FIFO push:** occurs when `M.c` is high and either count < FIFO_DEPTH or a pop happens on the same edge.
- **Drop:** when the push condition fails, the request is discarded. `overflow` sets to 1 and `drop_cnt` increments (saturating). Both clear only on reset.
- **Ordering:** FIFO order is preserved; results come out in request order.
- **Engine FSM:**
  - IDLE: if the FIFO is non-empty, pop, load the operands, clear the accumulator and `cnt`, go to CALC.
  - CALC: each cycle, if `B[cnt]` is 1, add `A<<cnt` to the accumulator (mod 2^(2*DW)). Increment `cnt`. After iteration 2*DW-1, go to DONE.
  - DONE: `S.f`=1 for this cycle only. If the FIFO is non-empty, pop and go to CALC; otherwise go to IDLE.
- **Output registers:** `S.d` and `S.e` are registered. They load when entering DONE and hold their value until the next DONE.
- **Reset values:** `S.d`=0, `S.e`=0, `S.f`=0, `overflow`=0, `drop_cnt`=0, `busy`=0, FIFO empty, FSM in IDLE.

## Timing
- **Latency:** a request captured at edge 0, with an empty FIFO and the engine in IDLE, is popped at edge 1. CALC covers edges 2 through 2*DW+1. `S.f` is high in the cycle following edge 2*DW+1, which is edge 9 for DW=4.
- **Throughput:** back-to-back queued requests produce one result every 2*DW+1 cycles. `S.f` pulses are never adjacent.
- **Full FIFO with a DONE/IDLE pop on the same edge:** the push is accepted and the count is unchanged.
- **Empty FIFO with a push and IDLE on the same edge:** the new entry is not visible to IDLE until the next edge. There is no bypass.
- **Reset mid-operation:** asynchronous reset clears all outputs immediately, including dropping `S.f`. The FIFO and the in-flight job are discarded, and no partial result is emitted.
- **`busy`:** combinational from the FSM state and the FIFO count.

## Test plan
- **Single request:** reset, then `a`=0x13, `b`=0x0B, `c`=1 for one cycle. Required: `S.f` pulse after edge 9 with `d`=0x1 and `e`=0xD (19*11=0xD1). `d` and `e` then hold, and `busy` returns to 0.
- **Wrap and upper-bit masking:** `a`=0xFFFF_FFFF, `b`=0x0000_00FF. Required: `d`=0x1, `e`=0x0 (0xFF*0xFF=0xFE01, truncated to 0x01).
- **Overflow:** six consecutive requests at edges 0 through 5 with operands (i, i+1) for i=1..6. Required: 5 `f` pulses in order, each 9 cycles apart, with products 2, 6, 12, 20, 30. The sixth request is dropped, `overflow`=1 and `drop_cnt`=1.
- **Saturation:** issue 300 requests while the FIFO is held full. Required: `drop_cnt` stops at 255 and `overflow` stays 1.
- **Reset mid-operation:** assert `rst_n`=0 during CALC with 2 entries queued. Required: all outputs go to 0 immediately. After release, no `f` pulse occurs until a new request arrives.
- **Zero operand:** `a`=0x5, `b`=0x0. Required: `d`=0, `e`=0, and the `f` pulse still occurs.
